clk_div_prog: RTL
=================

// Module: clk_div_prog
// PURPOSE
//   Runtime-programmable clock divider: derives a slow square wave (clk_out) and a
//   1-cycle rising-edge strobe (tick) from clk, with period N = div_val clk cycles.
//   Replaces the fixed /4 divider in the timing path feeding display/scan logic.
//   Divide ratio changes only at period boundaries, so clk_out never glitches.
// PARAMETERS
//   CNT_W        16  width of divide ratio and internal counter
//   DEFAULT_DIV  4   ratio active after reset (must be >= 2)
// PORTS
//   clk       in   1      system clock, all logic on rising edge
//   reset     in   1      synchronous, active-high reset
//   en        in   1      count enable; low freezes all divider state
//   div_val   in   CNT_W  requested divide ratio N, sampled when div_load=1
//   div_load  in   1      1-cycle request to adopt div_val
//   clk_out   out  1      divided clock, registered
//   tick      out  1      1-cycle pulse, coincident with each clk_out rising edge
//   div_ack   out  1      1-cycle pulse in the cycle a new ratio takes effect
// BEHAVIOUR
//   State: cnt[CNT_W], div_act[CNT_W], div_pend[CNT_W], pend_v.
//   Reset (reset=1 at posedge, overrides everything):
//     cnt=0, div_act=DEFAULT_DIV, pend_v=0, clk_out=0, tick=0, div_ack=0.
//   Clamp: any loaded value < 2 (0 or 1) is stored as 2. Max N = 2^CNT_W-1.
//   H = div_act>>1 (high-phase length). Odd N: high floor(N/2), low ceil(N/2).
//   Each cycle with en=1:
//     clk_out <= (cnt < H); tick <= (cnt == 0);
//     wrap = (cnt == div_act-1); cnt <= wrap ? 0 : cnt+1.
//   Outputs are registered; latency 1 cycle from cnt to clk_out/tick.
//   First cycle after reset release with en=1: clk_out=1, tick=1 at next edge.
//   Ratio update:
//     div_load=1 (any en): div_pend<=clamp(div_val), pend_v<=1. Last load wins.
//     On wrap with en=1: if pend_v or div_load, div_act<=new value
//       (div_load this cycle has priority over div_pend), pend_v<=0, div_ack<=1.
//     Otherwise div_ack<=0. New ratio governs the period starting at cnt=0.
//   en=0: cnt, div_act, clk_out hold; tick<=0, div_ack<=0; loads still captured.
//   reset mid-period: outputs low next cycle, pending load discarded, ratio
//     returns to DEFAULT_DIV.
//   No combinational path from any input to any output.
// TESTING
//   1. reset 2 cyc, en=1 -> clk_out 1,1,0,0 repeating; tick=1 on every 1st high
//      cycle; div_ack never asserted.
//   2. mid-period div_load with div_val=5 -> current /4 period completes; div_ack
//      pulses at wrap; then clk_out 1,1,0,0,0 repeating.
//   3. div_val=0 and separately div_val=1 -> both behave as /2: clk_out toggles
//      every cycle, tick every 2nd cycle.
//   4. en=0 for 3 cycles mid-high phase -> clk_out frozen at 1, tick=0; on en=1
//      sequence resumes exactly where it stopped (period stretched by 3).
//   5. loads of 6 then 3 before wrap -> single div_ack, ratio 3 (1 high, 2 low);
//      load of 8 in the wrap cycle itself -> /8 applies immediately.
//   6. reset asserted mid-period after pending load of 10 -> all outputs 0,
//      ratio back to 4, no div_ack; 1,1,0,0 pattern resumes after release.

Source files
------------

// File: rtl/clk_div_if.sv
// Control/status bundle for the programmable clock divider: ratio requests in,
// divided clock, tick strobe and ratio-change acknowledge out.
interface clk_div_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic             div_ack;

  // div_load is a 1-cycle request carrying div_val; it is always accepted.
  // div_ack pulses once when the latest request takes effect at a period boundary.
  modport master (
    output en,
    output div_val,
    output div_load,
    input  clk_out,
    input  tick,
    input  div_ack
  );

  modport slave (
    input  en,
    input  div_val,
    input  div_load,
    output clk_out,
    output tick,
    output div_ack
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider producing a glitch-free square wave and a
// rising-edge strobe; new ratios are adopted only at period boundaries.
module clk_div_prog #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  clk_div_if.slave   bus
);

  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_pend;
  logic             pend_v;
  logic             clk_out_q;
  logic             tick_q;
  logic             div_ack_q;

  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] next_div;
  logic             wrap;
  logic             change;

  // Ratios below 2 cannot form a square wave, so they are promoted to /2.
  always_comb begin
    load_val = (bus.div_val < MIN_DIV) ? MIN_DIV : bus.div_val;
    high_len = div_act >> 1;
    wrap     = (cnt == (div_act - ONE));
    change   = bus.div_load || pend_v;
    next_div = bus.div_load ? load_val : div_pend;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      div_act   <= DEF_DIV;
      div_pend  <= DEF_DIV;
      pend_v    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      div_ack_q <= 1'b0;
    end else begin
      if (bus.div_load) begin
        div_pend <= load_val;
        pend_v   <= 1'b1;
      end
      if (bus.en) begin
        clk_out_q <= (cnt < high_len);
        tick_q    <= (cnt == '0);
        if (wrap) begin
          cnt <= '0;
          // A load arriving in the wrap cycle itself applies to the next period.
          if (change) begin
            div_act   <= next_div;
            pend_v    <= 1'b0;
            div_ack_q <= 1'b1;
          end else begin
            div_ack_q <= 1'b0;
          end
        end else begin
          cnt       <= cnt + ONE;
          div_ack_q <= 1'b0;
        end
      end else begin
        tick_q    <= 1'b0;
        div_ack_q <= 1'b0;
      end
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.div_ack = div_ack_q;

endmodule
